ahb3lite_protocol_monitor: RTL and testbench
============================================

# ahb3lite_protocol_monitor

Synthesizable, passive AHB3-Lite protocol monitor that attaches to the HSEL/HADDR/control/HREADY/HRESP signals of any AHB3-Lite slave port. It implements the slave-port checks in hardware so they run in FPGA prototypes and silicon as well as in simulation. It adds burst-sequence tracking, wait-state timeout, two-cycle error-response checking, sticky per-check flags, a first-error code, and transfer/error counters. It never drives the bus.

## Interface
Parameters:
- HADDR_SIZE, 16, address width
- HDATA_SIZE, 32, data bus width; legal transfer sizes are at most HDATA_SIZE bits
- MAX_WAIT, 16, consecutive wait cycles that trigger TIMEOUT (≥2)
- CNT_W, 16, width of all counters

Ports:
- HCLK  in  1  bus clock; all state updates on its rising edge
- HRESET  in  1  asynchronous, active-high reset; clears all state immediately
- HSEL  in  1  slave select
- HADDR  in  HADDR_SIZE  address
- HWRITE  in  1  transfer direction
- HSIZE  in  3  transfer size
- HBURST  in  3  burst type
- HTRANS  in  2  transfer type
- HREADY  in  1  bus ready (mux output)
- HREADYOUT  in  1  ready driven by the monitored slave
- HRESP  in  1  slave response
- clr  in  1  synchronous clear of flags, first_err and counters
- err_flags  out  6  sticky violation flags, bit index = check ID
- first_err  out  3  ID+1 of the first violation since reset/clr; 0 = none
- err_cnt  out  CNT_W  cycles with ≥1 new violation; saturates at all-ones
- rd_cnt, wr_cnt  out  CNT_W  accepted read/write transfers; wrap modulo 2^CNT_W
- err_irq  out  1  registered OR of err_flags

## Operation
- Accepted transfer: HSEL & HREADY & HTRANS[1] at a rising edge. Increments rd_cnt or wr_cnt according to HWRITE.
- Check IDs; each is evaluated every cycle:
  - 0 ALIGN: accepted transfer with HADDR mod (1<<HSIZE) ≠ 0.
  - 1 SIZE: accepted transfer with (8<<HSIZE) > HDATA_SIZE.
  - 2 SEQ: any of the following:
    - SEQ or BUSY while the burst FSM is IDLE;
    - accepted SEQ whose HADDR ≠ expected address;
    - accepted SEQ after the last beat of a fixed-length burst.
  - Expected address, with bytes = 1<<HSIZE:
    - INCR*: previous + bytes.
    - WRAPn: boundary = n·bytes; (prev & ~(boundary−1)) | ((prev+bytes) & (boundary−1)).
  - 3 STABLE: previous edge saw HSEL & HTRANS[1] & !HREADY, and the current HADDR, HWRITE, HSIZE, HBURST or HTRANS differs from the stored copy. BUSY→SEQ is permitted.
  - 4 TIMEOUT: the wait counter reaches MAX_WAIT. It counts consecutive cycles with a data phase pending and HREADYOUT = 0, and fires once per stall.
  - 5 RESP: either of the following:
    - HRESP = 1 with HREADYOUT = 1 not preceded by a cycle of HRESP = 1 and HREADYOUT = 0;
    - RESP FSM in ERR1 and the next cycle is not HRESP = 1 with HREADYOUT = 1.
- Burst FSM (IDLE, BURST):
  - An accepted NONSEQ goes to BURST when HBURST ≠ SINGLE. It loads beats_left = 3/7/15 for 4/8/16-beat bursts, or "unbounded" for INCR.
  - An accepted SEQ decrements beats_left; reaching 0 returns the FSM to IDLE.
  - IDLE HTRANS returns the FSM to IDLE. An accepted NONSEQ restarts the burst.
- RESP FSM (OKAY, ERR1):
  - OKAY→ERR1 on HRESP = 1 & HREADYOUT = 0.
  - ERR1→OKAY on the next cycle in all cases.
- Flags are sticky until clr or HRESET.
- first_err loads only while it is 0. For simultaneous violations it takes the lowest ID.
- clr concurrent with a new violation: flags, first_err and err_cnt take only the new cycle's values (err_cnt = 1). rd_cnt/wr_cnt go to 0, or to 1 if a transfer is accepted in that same cycle.

## Timing
- Reset values:
  - err_flags, first_err, err_cnt, rd_cnt, wr_cnt and err_irq are 0.
  - Both FSMs are in their initial state (IDLE, OKAY); the wait counter is 0.
- Latency: a violation detected at edge N is visible on err_flags, first_err and err_cnt after edge N. err_irq is registered one edge later (N+1).
- Counters update at the accepting edge and are visible after it.
- HRESET assertion mid-burst or mid-stall aborts tracking immediately. The first transfer after release is treated as a fresh one: SEQ while IDLE flags check 2.
- Wait counter saturates at MAX_WAIT; it clears when HREADYOUT = 1 or no data phase is pending.

## Structure
- Shared package ahb3lite_pkg holds:
  - the existing HTRANS/HBURST/HRESP encodings;
  - chk_id_e (ALIGN=0 … RESP=5) and NUM_CHK = 6;
  - burst_state_t and resp_state_t enums.
- One sub-module, ahb3lite_burst_tracker, holds the burst FSM, beats_left and the expected-address logic. It outputs seq_err and burst_active.

## Test plan
- Reset, then clean traffic: WRITE NONSEQ 0x0010 (SIZE=2), then READ NONSEQ 0x0010 → err_flags = 0, wr_cnt = 1, rd_cnt = 1, first_err = 0.
- Misaligned access: NONSEQ HADDR = 0x0002, HSIZE = 2 → err_flags = 6'b000001, first_err = 1, err_cnt = 1; err_irq high one cycle later.
- Bursts:
  - WRAP4, SIZE = 2, start 0x0038 → beats 0x38, 0x3C, 0x30, 0x34 with no flag.
  - A fifth SEQ beat, or a SEQ to 0x40 in place of 0x30 → flag bit 2.
- Stall with MAX_WAIT = 4: HREADYOUT held low for 4 cycles → bit 4 set. Changing HADDR from 0x20 to 0x24 during the stall → bit 3 set.
- One-cycle ERROR: HRESP = 1 with HREADYOUT = 1 and no preceding low cycle → bit 5 set. A correct two-cycle ERROR sequence → no flag.
- Simultaneous events:
  - clr in the same cycle as an ALIGN violation → err_flags = 000001, err_cnt = 1.
  - HRESET pulse mid-burst, followed by SEQ → all outputs 0, then bit 2 set.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings, check identifiers and monitor FSM state types.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int NUM_CHK = 6;

  typedef enum logic [2:0] {
    CHK_ALIGN   = 3'd0,
    CHK_SIZE    = 3'd1,
    CHK_SEQ     = 3'd2,
    CHK_STABLE  = 3'd3,
    CHK_TIMEOUT = 3'd4,
    CHK_RESP    = 3'd5
  } chk_id_e;

  typedef enum logic {BST_IDLE, BST_BURST} burst_state_t;
  typedef enum logic {RSP_OKAY, RSP_ERR1} resp_state_t;

  // Beats remaining after the NONSEQ of a fixed-length burst.
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4, HBURST_INCR4:   burst_beats = 4'd3;
      HBURST_WRAP8, HBURST_INCR8:   burst_beats = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: burst_beats = 4'd15;
      default:                      burst_beats = 4'd0;
    endcase
  endfunction

  // ID+1 of the lowest set bit, 0 when no bit is set.
  function automatic logic [2:0] first_id(input logic [NUM_CHK-1:0] v);
    first_id = 3'd0;
    for (int i = NUM_CHK - 1; i >= 0; i--)
      if (v[i]) first_id = 3'(i + 1);
  endfunction

endpackage

// File: rtl/ahb3lite_burst_tracker.sv
// Tracks the current burst and flags SEQ beats that are out of place or
// carry an address other than the predicted next one.
module ahb3lite_burst_tracker
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  hsel,
  input  logic                  hready,
  input  logic [HADDR_SIZE-1:0] haddr,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [1:0]            htrans,
  output logic                  seq_err,
  output logic                  burst_active
);

  burst_state_t          state_q, state_d;
  logic [3:0]            beats_q, beats_d;
  logic                  unbounded_q, unbounded_d;
  logic [HADDR_SIZE-1:0] prev_q, prev_d;
  logic [2:0]            size_q, size_d;
  logic [2:0]            burst_q, burst_d;
  logic [HADDR_SIZE-1:0] bytes, wrap_mask, exp_addr;
  logic                  is_wrap, acc;

  assign acc          = hsel & hready & htrans[1];
  assign burst_active = (state_q == BST_BURST);
  assign bytes        = HADDR_SIZE'(1) << size_q;

  always_comb begin
    is_wrap   = 1'b0;
    wrap_mask = '0;
    case (burst_q)
      HBURST_WRAP4:  begin is_wrap = 1'b1; wrap_mask = (bytes << 2) - HADDR_SIZE'(1); end
      HBURST_WRAP8:  begin is_wrap = 1'b1; wrap_mask = (bytes << 3) - HADDR_SIZE'(1); end
      HBURST_WRAP16: begin is_wrap = 1'b1; wrap_mask = (bytes << 4) - HADDR_SIZE'(1); end
      default:       begin is_wrap = 1'b0; wrap_mask = '0; end
    endcase
    exp_addr = prev_q + bytes;
    if (is_wrap) exp_addr = (prev_q & ~wrap_mask) | (exp_addr & wrap_mask);
  end

  always_comb begin
    state_d     = state_q;
    beats_d     = beats_q;
    unbounded_d = unbounded_q;
    prev_d      = prev_q;
    size_d      = size_q;
    burst_d     = burst_q;
    seq_err     = 1'b0;
    if (hsel && htrans == HTRANS_SEQ && state_q == BST_IDLE) seq_err = 1'b1;
    if (acc && htrans == HTRANS_NONSEQ) begin
      prev_d      = haddr;
      size_d      = hsize;
      burst_d     = hburst;
      beats_d     = burst_beats(hburst);
      unbounded_d = (hburst == HBURST_INCR);
      state_d     = (hburst == HBURST_SINGLE) ? BST_IDLE : BST_BURST;
    end else if (acc && htrans == HTRANS_SEQ && state_q == BST_BURST) begin
      if (haddr != exp_addr) seq_err = 1'b1;
      prev_d = haddr;
      if (!unbounded_q) begin
        beats_d = beats_q - 4'd1;
        if (beats_q == 4'd1) state_d = BST_IDLE;
      end
    end else if (hsel && hready && htrans == HTRANS_IDLE) begin
      state_d = BST_IDLE;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= BST_IDLE;
      beats_q     <= '0;
      unbounded_q <= 1'b0;
      prev_q      <= '0;
      size_q      <= '0;
      burst_q     <= HBURST_SINGLE;
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      unbounded_q <= unbounded_d;
      prev_q      <= prev_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
    end
  end

endmodule

// File: rtl/ahb3lite_protocol_monitor.sv
// Passive AHB3-Lite slave-port checker: sticky violation flags, first-error
// code, error/transfer counters and a registered interrupt. Never drives the bus.
module ahb3lite_protocol_monitor
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 16,
  parameter int HDATA_SIZE = 32,
  parameter int MAX_WAIT   = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  input  logic                  HREADYOUT,
  input  logic                  HRESP,
  input  logic                  clr,
  output logic [NUM_CHK-1:0]    err_flags,
  output logic [2:0]            first_err,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      rd_cnt,
  output logic [CNT_W-1:0]      wr_cnt,
  output logic                  err_irq
);

  localparam int              WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [31:0]     DATA_BITS = 32'(HDATA_SIZE);
  localparam int              CTRL_W    = HADDR_SIZE + 10;

  logic                  acc, dphase_q, stall_q, seq_err, burst_active, trans_ok;
  logic [CTRL_W-1:0]     ctrl_now, ctrl_q;
  logic [WAIT_W-1:0]     wait_q;
  logic [HADDR_SIZE-1:0] size_mask;
  logic [NUM_CHK-1:0]    viol;
  resp_state_t           resp_q, resp_d;

  assign acc       = HSEL & HREADY & HTRANS[1];
  assign ctrl_now  = {HADDR, HWRITE, HSIZE, HBURST, HTRANS};
  assign size_mask = (HADDR_SIZE'(1) << HSIZE) - HADDR_SIZE'(1);
  // A stalled BUSY may legally advance to SEQ.
  assign trans_ok  = (ctrl_now[1:0] == ctrl_q[1:0]) ||
                     (ctrl_q[1:0] == HTRANS_BUSY && ctrl_now[1:0] == HTRANS_SEQ);

  ahb3lite_burst_tracker #(.HADDR_SIZE(HADDR_SIZE)) u_burst (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .hsel         (HSEL),
    .hready       (HREADY),
    .haddr        (HADDR),
    .hsize        (HSIZE),
    .hburst       (HBURST),
    .htrans       (HTRANS),
    .seq_err      (seq_err),
    .burst_active (burst_active)
  );

  always_comb begin
    resp_d = resp_q;
    case (resp_q)
      RSP_OKAY: if (HRESP == HRESP_ERROR && !HREADYOUT) resp_d = RSP_ERR1;
      RSP_ERR1: resp_d = RSP_OKAY;
      default:  resp_d = RSP_OKAY;
    endcase
  end

  always_comb begin
    viol              = '0;
    viol[CHK_ALIGN]   = acc && ((HADDR & size_mask) != '0);
    viol[CHK_SIZE]    = acc && ((32'd8 << HSIZE) > DATA_BITS);
    viol[CHK_SEQ]     = seq_err || (HSEL && HTRANS == HTRANS_BUSY && !burst_active);
    viol[CHK_STABLE]  = stall_q && ((ctrl_now[CTRL_W-1:2] != ctrl_q[CTRL_W-1:2]) || !trans_ok);
    viol[CHK_TIMEOUT] = dphase_q && !HREADYOUT && (wait_q == WAIT_LAST);
    viol[CHK_RESP]    = (HRESP == HRESP_ERROR && HREADYOUT && resp_q != RSP_ERR1) ||
                        (resp_q == RSP_ERR1 && !(HRESP == HRESP_ERROR && HREADYOUT));
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dphase_q <= 1'b0;
      stall_q  <= 1'b0;
      ctrl_q   <= '0;
      wait_q   <= '0;
      resp_q   <= RSP_OKAY;
    end else begin
      if (HREADY) dphase_q <= acc;
      stall_q <= HSEL & HTRANS[1] & !HREADY;
      ctrl_q  <= ctrl_now;
      resp_q  <= resp_d;
      if (dphase_q && !HREADYOUT) begin
        if (wait_q != WAIT_MAX) wait_q <= wait_q + WAIT_W'(1);
      end else begin
        wait_q <= '0;
      end
    end
  end

  // clr discards history but still records whatever happens in its own cycle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      err_flags <= '0;
      first_err <= '0;
      err_cnt   <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      err_irq   <= 1'b0;
    end else begin
      err_irq <= |err_flags;
      if (clr) begin
        err_flags <= viol;
        first_err <= first_id(viol);
        err_cnt   <= CNT_W'(viol != '0);
        rd_cnt    <= CNT_W'(acc & !HWRITE);
        wr_cnt    <= CNT_W'(acc & HWRITE);
      end else begin
        err_flags <= err_flags | viol;
        if (first_err == 3'd0) first_err <= first_id(viol);
        if (viol != '0 && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        if (acc && HWRITE) wr_cnt <= wr_cnt + CNT_W'(1);
        if (acc && !HWRITE) rd_cnt <= rd_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ahb3lite_protocol_monitor.sv
// Directed bench for ahb3lite_protocol_monitor: expected values are queued as
// stimulus is applied and compared by an independent monitor process.
module tb_ahb3lite_protocol_monitor;
  import ahb3lite_pkg::*;

  localparam int AW    = 16;
  localparam int CNT_W = 16;

  localparam int F_FLAGS  = 0;
  localparam int F_FIRST  = 1;
  localparam int F_ERRCNT = 2;
  localparam int F_RD     = 3;
  localparam int F_WR     = 4;
  localparam int F_IRQ    = 5;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          HSEL = 1'b0;
  logic [AW-1:0] HADDR = '0;
  logic          HWRITE = 1'b0;
  logic [2:0]    HSIZE = 3'd0;
  logic [2:0]    HBURST = 3'd0;
  logic [1:0]    HTRANS = 2'b00;
  logic          HREADY;
  logic          HREADYOUT = 1'b1;
  logic          HRESP = 1'b0;
  logic          clr = 1'b0;
  logic [5:0]       err_flags;
  logic [2:0]       first_err;
  logic [CNT_W-1:0] err_cnt, rd_cnt, wr_cnt;
  logic             err_irq;

  assign HREADY = HREADYOUT;

  ahb3lite_protocol_monitor #(
    .HADDR_SIZE(AW), .HDATA_SIZE(32), .MAX_WAIT(4), .CNT_W(CNT_W)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .clr(clr),
    .err_flags(err_flags), .first_err(first_err), .err_cnt(err_cnt),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_irq(err_irq)
  );

  // clock / reset
  always #5 HCLK = ~HCLK;

  // scoreboard
  typedef struct {
    string       name;
    int          fld;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [15:0] actual(input int fld);
    case (fld)
      F_FLAGS:  actual = 16'(err_flags);
      F_FIRST:  actual = 16'(first_err);
      F_ERRCNT: actual = 16'(err_cnt);
      F_RD:     actual = 16'(rd_cnt);
      F_WR:     actual = 16'(wr_cnt);
      default:  actual = 16'(err_irq);
    endcase
  endfunction

  always @(negedge HCLK) begin
    exp_t        e;
    logic [15:0] act;
    #2;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = actual(e.fld);
      n_vec++;
      if (act !== e.val) begin
        n_err++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
      end
    end
  end

  // driver tasks
  task automatic expect_v(input string name, input int fld, input logic [15:0] val);
    exp_t e;
    e.name = name;
    e.fld  = fld;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic bus(input logic sel, input logic [1:0] trans, input logic [AW-1:0] addr,
                     input logic write, input logic [2:0] size, input logic [2:0] burst,
                     input logic rdy);
    HSEL      = sel;
    HTRANS    = trans;
    HADDR     = addr;
    HWRITE    = write;
    HSIZE     = size;
    HBURST    = burst;
    HREADYOUT = rdy;
    @(negedge HCLK);
  endtask

  task automatic idle(input logic rdy);
    bus(1'b0, HTRANS_IDLE, '0, 1'b0, 3'd0, HBURST_SINGLE, rdy);
  endtask

  task automatic clear_all();
    clr = 1'b1;
    idle(1'b1);
    clr = 1'b0;
  endtask

  task automatic expect_all_zero(input string tag);
    expect_v({tag, "_flags"}, F_FLAGS, 16'h0);
    expect_v({tag, "_first"}, F_FIRST, 16'h0);
    expect_v({tag, "_errcnt"}, F_ERRCNT, 16'h0);
    expect_v({tag, "_rd"}, F_RD, 16'h0);
    expect_v({tag, "_wr"}, F_WR, 16'h0);
    expect_v({tag, "_irq"}, F_IRQ, 16'h0);
  endtask

  initial begin
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    expect_all_zero("reset");

    // clean write then read
    bus(1'b1, HTRANS_NONSEQ, 16'h0010, 1'b1, 3'd2, HBURST_SINGLE, 1'b1);
    bus(1'b1, HTRANS_NONSEQ, 16'h0010, 1'b0, 3'd2, HBURST_SINGLE, 1'b1);
    idle(1'b1);
    expect_v("clean_flags", F_FLAGS, 16'h0);
    expect_v("clean_first", F_FIRST, 16'h0);
    expect_v("clean_wr", F_WR, 16'd1);
    expect_v("clean_rd", F_RD, 16'd1);

    // misaligned word access
    bus(1'b1, HTRANS_NONSEQ, 16'h0002, 1'b0, 3'd2, HBURST_SINGLE, 1'b1);
    expect_v("align_flags", F_FLAGS, 16'h01);
    expect_v("align_first", F_FIRST, 16'd1);
    expect_v("align_errcnt", F_ERRCNT, 16'd1);
    expect_v("align_irq_early", F_IRQ, 16'd0);
    expect_v("align_rd", F_RD, 16'd2);
    idle(1'b1);
    expect_v("align_irq", F_IRQ, 16'd1);
    clear_all();
    expect_v("clr_flags", F_FLAGS, 16'h0);
    expect_v("clr_first", F_FIRST, 16'h0);
    expect_v("clr_rd", F_RD, 16'd0);
    idle(1'b1);

    // WRAP4 burst, then a fifth beat
    bus(1'b1, HTRANS_NONSEQ, 16'h0038, 1'b0, 3'd2, HBURST_WRAP4, 1'b1);
    bus(1'b1, HTRANS_SEQ,    16'h003C, 1'b0, 3'd2, HBURST_WRAP4, 1'b1);
    bus(1'b1, HTRANS_SEQ,    16'h0030, 1'b0, 3'd2, HBURST_WRAP4, 1'b1);
    bus(1'b1, HTRANS_SEQ,    16'h0034, 1'b0, 3'd2, HBURST_WRAP4, 1'b1);
    expect_v("wrap4_flags", F_FLAGS, 16'h0);
    expect_v("wrap4_rd", F_RD, 16'd4);
    bus(1'b1, HTRANS_SEQ,    16'h0038, 1'b0, 3'd2, HBURST_WRAP4, 1'b1);
    expect_v("beat5_flags", F_FLAGS, 16'h04);
    expect_v("beat5_first", F_FIRST, 16'd3);
    idle(1'b1);
    clear_all();

    // WRAP4 with a wrong wrap address
    bus(1'b1, HTRANS_NONSEQ, 16'h0038, 1'b0, 3'd2, HBURST_WRAP4, 1'b1);
    bus(1'b1, HTRANS_SEQ,    16'h003C, 1'b0, 3'd2, HBURST_WRAP4, 1'b1);
    expect_v("wrap_ok_flags", F_FLAGS, 16'h0);
    bus(1'b1, HTRANS_SEQ,    16'h0040, 1'b0, 3'd2, HBURST_WRAP4, 1'b1);
    expect_v("wrapaddr_flags", F_FLAGS, 16'h04);
    expect_v("wrapaddr_errcnt", F_ERRCNT, 16'd1);
    idle(1'b1);
    clear_all();

    // wait-state timeout at four stalled cycles
    bus(1'b1, HTRANS_NONSEQ, 16'h0020, 1'b0, 3'd2, HBURST_SINGLE, 1'b1);
    repeat (3) idle(1'b0);
    expect_v("stall3_flags", F_FLAGS, 16'h0);
    idle(1'b0);
    expect_v("timeout_flags", F_FLAGS, 16'h10);
    expect_v("timeout_first", F_FIRST, 16'd5);
    idle(1'b0);
    expect_v("timeout_once", F_ERRCNT, 16'd1);
    idle(1'b1);
    clear_all();

    // address change while the next transfer is stalled
    bus(1'b1, HTRANS_NONSEQ, 16'h0000, 1'b0, 3'd2, HBURST_SINGLE, 1'b1);
    bus(1'b1, HTRANS_NONSEQ, 16'h0020, 1'b0, 3'd2, HBURST_SINGLE, 1'b0);
    bus(1'b1, HTRANS_NONSEQ, 16'h0020, 1'b0, 3'd2, HBURST_SINGLE, 1'b0);
    expect_v("stable_hold_flags", F_FLAGS, 16'h0);
    bus(1'b1, HTRANS_NONSEQ, 16'h0024, 1'b0, 3'd2, HBURST_SINGLE, 1'b0);
    expect_v("stable_flags", F_FLAGS, 16'h08);
    expect_v("stable_first", F_FIRST, 16'd4);
    bus(1'b1, HTRANS_NONSEQ, 16'h0024, 1'b0, 3'd2, HBURST_SINGLE, 1'b1);
    idle(1'b1);
    expect_v("stable_errcnt", F_ERRCNT, 16'd1);
    expect_v("stable_rd", F_RD, 16'd2);
    clear_all();

    // oversize and misaligned together: lowest ID wins
    bus(1'b1, HTRANS_NONSEQ, 16'h0004, 1'b0, 3'd3, HBURST_SINGLE, 1'b1);
    expect_v("size_flags", F_FLAGS, 16'h03);
    expect_v("size_first", F_FIRST, 16'd1);
    bus(1'b1, HTRANS_NONSEQ, 16'h0000, 1'b0, 3'd2, HBURST_SINGLE, 1'b1);
    expect_v("size_errcnt", F_ERRCNT, 16'd1);
    idle(1'b1);
    clear_all();

    // single-cycle ERROR response
    HRESP = 1'b1;
    idle(1'b1);
    HRESP = 1'b0;
    expect_v("resp1_flags", F_FLAGS, 16'h20);
    expect_v("resp1_first", F_FIRST, 16'd6);
    clear_all();

    // correct two-cycle ERROR
    HRESP = 1'b1;
    idle(1'b0);
    idle(1'b1);
    HRESP = 1'b0;
    idle(1'b1);
    expect_v("resp2_flags", F_FLAGS, 16'h0);

    // first ERROR cycle not followed by the second
    HRESP = 1'b1;
    idle(1'b0);
    HRESP = 1'b0;
    idle(1'b1);
    expect_v("resp_trunc_flags", F_FLAGS, 16'h20);
    expect_v("resp_trunc_errcnt", F_ERRCNT, 16'd1);

    // clr together with a misaligned write
    clr = 1'b1;
    bus(1'b1, HTRANS_NONSEQ, 16'h0002, 1'b1, 3'd2, HBURST_SINGLE, 1'b1);
    clr = 1'b0;
    expect_v("clrviol_flags", F_FLAGS, 16'h01);
    expect_v("clrviol_first", F_FIRST, 16'd1);
    expect_v("clrviol_errcnt", F_ERRCNT, 16'd1);
    expect_v("clrviol_wr", F_WR, 16'd1);
    expect_v("clrviol_rd", F_RD, 16'd0);

    // asynchronous reset in the middle of an INCR4 burst
    bus(1'b1, HTRANS_NONSEQ, 16'h0000, 1'b0, 3'd2, HBURST_INCR4, 1'b1);
    bus(1'b1, HTRANS_SEQ,    16'h0004, 1'b0, 3'd2, HBURST_INCR4, 1'b1);
    HRESET = 1'b1;
    expect_all_zero("midreset");
    idle(1'b1);
    HRESET = 1'b0;
    bus(1'b1, HTRANS_SEQ,    16'h0008, 1'b0, 3'd2, HBURST_INCR4, 1'b1);
    expect_v("postreset_flags", F_FLAGS, 16'h04);
    expect_v("postreset_first", F_FIRST, 16'd3);
    expect_v("postreset_rd", F_RD, 16'd1);
    idle(1'b1);

    // report
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge HCLK);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
